// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write-port arbiter.
//   XLEN      : data width
//   NREG      : number of architectural registers
//   REG_IDX_W : register index width
//   X0        : hard-wired zero register index
//   wb_req_t  : one write-back request {valid, rd, data}
package regfile_pkg;

    localparam int XLEN      = 32;
    localparam int NREG      = 32;
    localparam int REG_IDX_W = 5;

    localparam logic [REG_IDX_W-1:0] X0 = '0;

    typedef struct packed {
        logic                 valid;
        logic [REG_IDX_W-1:0] rd;
        logic [XLEN-1:0]      data;
    } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_scoreboard.sv
// Busy-register scoreboard for outstanding loads.
// Tracks which registers have a load in flight and how many loads are
// outstanding. It also collects the load-protocol error sources into a
// sticky flag.
//   clk, rst        : clock, synchronous active-high reset
//   ld_issue        : decode issues a load to ld_issue_rd
//   ld_valid        : load data returns for ld_rd
//   busy            : one bit per register, set while a load is pending
//   ld_issue_ready  : fewer than MAX_LOADS loads outstanding
//   err             : sticky protocol-violation flag
module reg_scoreboard
    import regfile_pkg::*;
#(
    parameter int MAX_LOADS = 4,
    parameter int NREG_P    = regfile_pkg::NREG
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ld_issue,
    input  logic [REG_IDX_W-1:0] ld_issue_rd,
    input  logic                 ld_valid,
    input  logic [REG_IDX_W-1:0] ld_rd,
    output logic [NREG_P-1:0]    busy,
    output logic                 ld_issue_ready,
    output logic                 err
);

    localparam int CNT_W = $clog2(MAX_LOADS + 1);

    logic [CNT_W-1:0]  ld_cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [NREG_P-1:0] busy_nxt;
    logic              issue_acc;
    logic              err_event;

    assign ld_issue_ready = (ld_cnt < CNT_W'(MAX_LOADS));
    assign issue_acc      = ld_issue && ld_issue_ready;

    // A return for a register with nothing pending, a return with no load
    // outstanding at all, and an issue while full are all protocol errors.
    assign err_event = (ld_valid && (ld_rd != X0) && !busy[ld_rd])
                    || (ld_valid && (ld_cnt == '0))
                    || (ld_issue && !ld_issue_ready);

    always_comb begin
        cnt_nxt = ld_cnt;
        if (issue_acc && !ld_valid) begin
            cnt_nxt = ld_cnt + 1'b1;
        end else if (!issue_acc && ld_valid && (ld_cnt != '0)) begin
            cnt_nxt = ld_cnt - 1'b1;
        end
    end

    // Clear before set so a new issue to the register that is returning
    // this cycle keeps it busy.
    always_comb begin
        busy_nxt = busy;
        if (ld_valid) begin
            busy_nxt[ld_rd] = 1'b0;
        end
        if (issue_acc && (ld_issue_rd != X0)) begin
            busy_nxt[ld_issue_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy   <= '0;
            ld_cnt <= '0;
            err    <= 1'b0;
        end else begin
            busy   <= busy_nxt;
            ld_cnt <= cnt_nxt;
            if (err_event) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter.
// Shares the single register-file write port between ALU writeback and
// load return, and drives the decode stall from the load scoreboard and
// the pending hold entry.
//   clk, rst                         : clock, synchronous active-high reset
//   alu_valid/alu_rd/alu_data        : ALU writeback request
//   alu_ready                        : ALU request accepted this cycle
//   ld_issue/ld_issue_rd             : load issued by decode
//   ld_issue_ready                   : room for another outstanding load
//   ld_valid/ld_rd/ld_data           : load data return (always accepted)
//   dec_rs1/dec_rs2/dec_rd/dec_uses_rd : decode operands
//   stall                            : decode must hold this cycle
//   rf_write/rf_rd_addr/rf_rd_data   : register-file write port
//   err                              : sticky protocol-violation flag
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int MAX_LOADS = 4,
    parameter int XLEN      = regfile_pkg::XLEN,
    parameter int NREG      = regfile_pkg::NREG
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alu_valid,
    input  logic [REG_IDX_W-1:0] alu_rd,
    input  logic [XLEN-1:0]      alu_data,
    output logic                 alu_ready,
    input  logic                 ld_issue,
    input  logic [REG_IDX_W-1:0] ld_issue_rd,
    output logic                 ld_issue_ready,
    input  logic                 ld_valid,
    input  logic [REG_IDX_W-1:0] ld_rd,
    input  logic [XLEN-1:0]      ld_data,
    input  logic [REG_IDX_W-1:0] dec_rs1,
    input  logic [REG_IDX_W-1:0] dec_rs2,
    input  logic [REG_IDX_W-1:0] dec_rd,
    input  logic                 dec_uses_rd,
    output logic                 stall,
    output logic                 rf_write,
    output logic [REG_IDX_W-1:0] rf_rd_addr,
    output logic [XLEN-1:0]      rf_rd_data,
    output logic                 err
);

    logic                 hold_valid;
    logic [REG_IDX_W-1:0] hold_rd;
    logic [XLEN-1:0]      hold_data;
    logic [NREG-1:0]      busy;

    reg_scoreboard #(
        .MAX_LOADS (MAX_LOADS),
        .NREG_P    (NREG)
    ) u_scoreboard (
        .clk            (clk),
        .rst            (rst),
        .ld_issue       (ld_issue),
        .ld_issue_rd    (ld_issue_rd),
        .ld_valid       (ld_valid),
        .ld_rd          (ld_rd),
        .busy           (busy),
        .ld_issue_ready (ld_issue_ready),
        .err            (err)
    );

    assign alu_ready = !hold_valid;

    // Load return wins, then the held ALU write, then a fresh ALU write.
    always_comb begin
        rf_write   = 1'b0;
        rf_rd_addr = '0;
        rf_rd_data = '0;
        if (ld_valid) begin
            rf_write   = 1'b1;
            rf_rd_addr = ld_rd;
            rf_rd_data = ld_data;
        end else if (hold_valid) begin
            rf_write   = 1'b1;
            rf_rd_addr = hold_rd;
            rf_rd_data = hold_data;
        end else if (alu_valid && alu_ready) begin
            rf_write   = 1'b1;
            rf_rd_addr = alu_rd;
            rf_rd_data = alu_data;
        end
    end

    // The hold entry survives a burst of load returns and drains on the
    // first quiet cycle. alu_ready is low while it is full, so a new
    // capture can never coincide with a drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid <= 1'b0;
        end else if (hold_valid) begin
            if (!ld_valid) begin
                hold_valid <= 1'b0;
            end
        end else if (alu_valid && ld_valid) begin
            hold_valid <= 1'b1;
            hold_rd    <= alu_rd;
            hold_data  <= alu_data;
        end
    end

    // Writes that land on the edge where the read address latches are
    // visible to the read, so only pending loads and the unwritten hold
    // entry block decode.
    assign stall = ((dec_rs1 != X0) && busy[dec_rs1])
                || ((dec_rs2 != X0) && busy[dec_rs2])
                || (hold_valid && ((hold_rd == dec_rs1) || (hold_rd == dec_rs2)))
                || (dec_uses_rd && busy[dec_rd]);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        ld_issue;
    logic [4:0]  ld_issue_rd;
    logic        ld_issue_ready;
    logic        ld_valid;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic [4:0]  dec_rs1;
    logic [4:0]  dec_rs2;
    logic [4:0]  dec_rd;
    logic        dec_uses_rd;
    logic        stall;
    logic        rf_write;
    logic [4:0]  rf_rd_addr;
    logic [31:0] rf_rd_data;
    logic        err;

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        string       tag;
        logic        wr;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        ardy;
        logic        stl;
        logic        ldr;
        logic        er;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;

    logic [31:0] rf [32];

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.MAX_LOADS(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .alu_valid      (alu_valid),
        .alu_rd         (alu_rd),
        .alu_data       (alu_data),
        .alu_ready      (alu_ready),
        .ld_issue       (ld_issue),
        .ld_issue_rd    (ld_issue_rd),
        .ld_issue_ready (ld_issue_ready),
        .ld_valid       (ld_valid),
        .ld_rd          (ld_rd),
        .ld_data        (ld_data),
        .dec_rs1        (dec_rs1),
        .dec_rs2        (dec_rs2),
        .dec_rd         (dec_rd),
        .dec_uses_rd    (dec_uses_rd),
        .stall          (stall),
        .rf_write       (rf_write),
        .rf_rd_addr     (rf_rd_addr),
        .rf_rd_data     (rf_rd_data),
        .err            (err)
    );

    // Register file fed by the write port, so loaded values can be read back.
    always @(posedge clk) begin
        if (rf_write) rf[rf_rd_addr] <= rf_rd_data;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input string tag, input logic wr, input logic [4:0] addr,
                            input logic [31:0] data, input logic ardy, input logic stl,
                            input logic ldr, input logic er);
        exp_t x;
        x.tag = tag; x.wr = wr; x.addr = addr; x.data = data;
        x.ardy = ardy; x.stl = stl; x.ldr = ldr; x.er = er;
        exp_q.push_back(x);
    endtask

    // Outputs are compared mid-cycle, away from the rising edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({e.tag, ".rf_write"},   32'(rf_write),       32'(e.wr));
            chk({e.tag, ".rf_rd_addr"}, 32'(rf_rd_addr),     32'(e.addr));
            chk({e.tag, ".rf_rd_data"}, rf_rd_data,          e.data);
            chk({e.tag, ".alu_ready"},  32'(alu_ready),      32'(e.ardy));
            chk({e.tag, ".stall"},      32'(stall),          32'(e.stl));
            chk({e.tag, ".ld_ready"},   32'(ld_issue_ready), 32'(e.ldr));
            chk({e.tag, ".err"},        32'(err),            32'(e.er));
        end
    end

    task automatic idle();
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        ld_issue = 0; ld_issue_rd = 0;
        ld_valid = 0; ld_rd = 0; ld_data = 0;
        dec_rs1 = 0; dec_rs2 = 0; dec_rd = 0; dec_uses_rd = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic issue(input logic [4:0] rd, input string tag, input logic ldr, input logic er);
        ld_issue = 1; ld_issue_rd = rd;
        push_exp(tag, 0, 0, 0, 1, 0, ldr, er);
        tick();
    endtask

    task automatic ret(input logic [4:0] rd, input logic [31:0] d, input string tag,
                       input logic ldr, input logic er);
        ld_valid = 1; ld_rd = rd; ld_data = d;
        push_exp(tag, 1, rd, d, 1, 0, ldr, er);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;

        push_exp("reset", 0, 0, 0, 1, 0, 1, 0); tick();

        // Direct ALU write
        alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
        push_exp("alu_direct", 1, 5, 32'hDEADBEEF, 1, 0, 1, 0); tick();

        // Load beats ALU; ALU parked in hold and written next cycle
        issue(3, "iss3", 1, 0);
        ld_valid = 1; ld_rd = 3; ld_data = 32'h11;
        alu_valid = 1; alu_rd = 4; alu_data = 32'h22;
        push_exp("ld_vs_alu", 1, 3, 32'h11, 1, 0, 1, 0); tick();
        dec_rs1 = 4;
        push_exp("hold_drain", 1, 4, 32'h22, 0, 1, 1, 0); tick();
        dec_rs1 = 4;
        push_exp("hold_done", 0, 0, 0, 1, 0, 1, 0); tick();
        chk("rf_x3", rf[3], 32'h11);
        chk("rf_x4", rf[4], 32'h22);
        chk("rf_x5", rf[5], 32'hDEADBEEF);

        // RAW on a pending load
        issue(9, "iss9", 1, 0);
        dec_rs2 = 9;
        push_exp("raw9_wait", 0, 0, 0, 1, 1, 1, 0); tick();
        dec_rs2 = 9; ld_valid = 1; ld_rd = 9; ld_data = 32'h99;
        push_exp("raw9_ret", 1, 9, 32'h99, 1, 1, 1, 0); tick();
        dec_rs2 = 9;
        push_exp("raw9_free", 0, 0, 0, 1, 0, 1, 0); tick();
        chk("rf_x9", rf[9], 32'h99);

        // WAW on a pending load
        issue(10, "iss10", 1, 0);
        dec_uses_rd = 1; dec_rd = 10;
        push_exp("waw", 0, 0, 0, 1, 1, 1, 0); tick();
        dec_uses_rd = 1; dec_rd = 10; ld_valid = 1; ld_rd = 10; ld_data = 32'hA;
        push_exp("waw_ret", 1, 10, 32'hA, 1, 1, 1, 0); tick();
        dec_uses_rd = 1; dec_rd = 10;
        push_exp("waw_free", 0, 0, 0, 1, 0, 1, 0); tick();

        // Hold survives a two-cycle load burst
        issue(6, "iss6", 1, 0);
        issue(7, "iss7", 1, 0);
        ld_valid = 1; ld_rd = 6; ld_data = 32'h66;
        alu_valid = 1; alu_rd = 8; alu_data = 32'h88;
        push_exp("burst_ld6", 1, 6, 32'h66, 1, 0, 1, 0); tick();
        ld_valid = 1; ld_rd = 7; ld_data = 32'h77; dec_rs2 = 8;
        push_exp("burst_ld7", 1, 7, 32'h77, 0, 1, 1, 0); tick();
        push_exp("burst_hold", 1, 8, 32'h88, 0, 0, 1, 0); tick();
        push_exp("burst_done", 0, 0, 0, 1, 0, 1, 0); tick();

        // Outstanding-load limit
        issue(1, "cap_iss1", 1, 0);
        issue(2, "cap_iss2", 1, 0);
        issue(3, "cap_iss3", 1, 0);
        issue(4, "cap_iss4", 1, 0);
        ld_issue = 1; ld_issue_rd = 5;
        push_exp("cap_full", 0, 0, 0, 1, 0, 0, 0); tick();
        dec_rs1 = 5;
        push_exp("cap_reject", 0, 0, 0, 1, 0, 0, 1); tick();
        ret(2, 32'h2, "cap_ret2", 0, 1);
        issue(2, "cap_reiss2", 1, 1);
        ret(4, 32'h4, "cap_ret4", 0, 1);
        ld_issue = 1; ld_issue_rd = 2; ld_valid = 1; ld_rd = 2; ld_data = 32'h2B;
        push_exp("iss_ret_same", 1, 2, 32'h2B, 1, 0, 1, 1); tick();
        dec_rs1 = 2; ld_issue = 1; ld_issue_rd = 4;
        push_exp("set_wins", 0, 0, 0, 1, 1, 1, 1); tick();
        push_exp("cnt_kept", 0, 0, 0, 1, 0, 0, 1); tick();

        // Reset while a write is held and a load is pending
        ret(1, 32'h1, "pre_rst_ret1", 0, 1);
        issue(7, "pre_rst_iss7", 1, 1);
        ld_valid = 1; ld_rd = 3; ld_data = 32'h33;
        alu_valid = 1; alu_rd = 8; alu_data = 32'h88;
        push_exp("pre_rst_hold", 1, 3, 32'h33, 1, 0, 0, 1); tick();
        rst = 1; dec_rs1 = 7;
        push_exp("rst_cycle", 1, 8, 32'h88, 0, 1, 1, 1); tick();
        rst = 0; dec_rs1 = 7; dec_rs2 = 8; dec_uses_rd = 1; dec_rd = 2;
        push_exp("post_rst", 0, 0, 0, 1, 0, 1, 0); tick();

        // Spurious return and x0 issue
        ret(12, 32'hC, "spurious12", 1, 0);
        push_exp("err_set", 0, 0, 0, 1, 0, 1, 1); tick();
        dec_uses_rd = 1; dec_rd = 0;
        issue(0, "iss_x0", 1, 1);
        dec_uses_rd = 1; dec_rd = 0; dec_rs1 = 0;
        issue(1, "x0_free", 1, 1);
        issue(2, "x0_iss2", 1, 1);
        issue(3, "x0_iss3", 1, 1);
        push_exp("x0_counted", 0, 0, 0, 1, 0, 0, 1); tick();

        @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
